// File: rtl/myprotocol_rx.sv
// Receiver for the three-wire myprotocol link: reassembles MSB-first frames and flags bad ones.
// Optional even-parity bit per frame is enabled by defining MYPROTO_RX_PARITY_EN.
module myprotocol_rx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig1,
  input  logic              sig2,
  input  logic              sig3,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

`ifdef MYPROTO_RX_PARITY_EN
  localparam int unsigned Exp = DATA_W + 1;
`else
  localparam int unsigned Exp = DATA_W;
`endif
  localparam int unsigned CntW = $clog2(Exp + 1);
  localparam logic [CntW-1:0] ExpCnt     = CntW'(Exp);
  localparam logic [7:0]      TimeoutGap = 8'(TIMEOUT);

  typedef enum logic [1:0] {StSync, StIdle, StRecv, StErr} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]         gap_q, gap_d, gap_inc;
  logic [Exp-1:0]     shift_q, shift_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rx_err_q, rx_err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               busy_q;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               strobe;

  assign strobe  = sig3 & sig1;
  assign gap_inc = (gap_q == 8'hff) ? gap_q : gap_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_d       = gap_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_err_d    = 1'b0;
    err_code_d  = err_code_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      StSync: begin
        if (!sig1) state_d = StIdle;
      end
      StIdle: begin
        if (sig1) begin
          state_d = StRecv;
          gap_d   = 8'd0;
          if (strobe) begin
            bit_cnt_d = CntW'(1);
            shift_d   = {{(Exp-1){1'b0}}, sig2};
          end else begin
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
      end
      StRecv: begin
        if (strobe) begin
          if (bit_cnt_q == ExpCnt) begin
            state_d    = StErr;
            rx_err_d   = 1'b1;
            err_code_d = 2'b10;
          end else begin
            shift_d   = {shift_q[Exp-2:0], sig2};
            bit_cnt_d = bit_cnt_q + CntW'(1);
            gap_d     = 8'd0;
          end
        end else begin
          gap_d = gap_inc;
          // Timeout outranks a frame end seen in the same cycle.
          if (gap_inc >= TimeoutGap) begin
            state_d    = StErr;
            rx_err_d   = 1'b1;
            err_code_d = 2'b11;
          end else if (!sig1) begin
            state_d = StIdle;
            if (bit_cnt_q != ExpCnt) begin
              rx_err_d   = 1'b1;
              err_code_d = 2'b01;
            end else begin
`ifdef MYPROTO_RX_PARITY_EN
              if (^shift_q) begin
                rx_err_d   = 1'b1;
                err_code_d = 2'b00;
              end else begin
                rx_data_d   = shift_q[Exp-1 -: DATA_W];
                rx_valid_d  = 1'b1;
                frame_cnt_d = frame_cnt_q + 8'd1;
              end
`else
              rx_data_d   = shift_q[Exp-1 -: DATA_W];
              rx_valid_d  = 1'b1;
              frame_cnt_d = frame_cnt_q + 8'd1;
`endif
            end
          end
        end
      end
      StErr: begin
        if (!sig1) state_d = StIdle;
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StSync;
      bit_cnt_q   <= '0;
      gap_q       <= 8'd0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      err_code_q  <= 2'b00;
      busy_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_q       <= gap_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_err_q    <= rx_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= (state_d == StRecv);
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_err    = rx_err_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_myprotocol_rx.sv
// Self-checking bench for myprotocol_rx: frame table plus hand-built timeout and reset sequences.
module tb_myprotocol_rx;

`ifdef MYPROTO_RX_PARITY_EN
  localparam int E = 9;
`else
  localparam int E = 8;
`endif

  logic       clk, rst, sig1, sig2, sig3;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err;
  logic [1:0] err_code;
  logic       busy;
  logic [7:0] frame_cnt;

  myprotocol_rx #(.DATA_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .sig1(sig1), .sig2(sig2), .sig3(sig3),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .err_code(err_code), .busy(busy), .frame_cnt(frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          space;
    logic        cfall;
    logic        kerr;
    logic [1:0]  code;
    logic [7:0]  data;
  } vec_t;

  typedef struct {
    logic       is_err;
    logic [1:0] code;
    logic [7:0] data;
    logic [7:0] cnt;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  vec_t       vecs[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         ngood = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [7:0] mdata = 8'd0;
  logic [7:0] mcnt = 8'd0;
  logic [1:0] mcode = 2'b00;

  function automatic logic [15:0] mk(input logic [7:0] d);
`ifdef MYPROTO_RX_PARITY_EN
    return {7'b0, d, ^d};
`else
    return {8'b0, d};
`endif
  endfunction

  function automatic vec_t mkv(input logic [15:0] bits, input int nbits, input int space,
                               input logic cfall, input logic kerr, input logic [1:0] code,
                               input logic [7:0] data);
    vec_t v;
    v.bits = bits; v.nbits = nbits; v.space = space; v.cfall = cfall;
    v.kerr = kerr; v.code = code; v.data = data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push(input logic is_err, input logic [1:0] code, input logic [7:0] data);
    exp_t e;
    if (!is_err) exp_cnt = exp_cnt + 8'd1;
    e.is_err = is_err; e.code = code; e.data = data; e.cnt = exp_cnt; e.due = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic check_outputs();
    exp_t e;
    if (rx_valid && rx_err) chk("valid_and_err", 32'd1, 32'd0);
    if (rx_valid || rx_err) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_event: got valid=%0b err=%0b code=%0b want none (cycle %0d)",
                 rx_valid, rx_err, err_code, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("event_cycle", cyc, e.due);
        chk("event_is_err", 32'(rx_err), 32'(e.is_err));
        if (e.is_err) mcode = e.code;
        else begin
          mdata = e.data; mcnt = e.cnt; ngood++;
        end
      end
    end
    if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      total++; bad++;
      $display("FAIL missed_event: got nothing want is_err=%0b code=%0b at cycle %0d",
               e.is_err, e.code, e.due);
    end
    chk("rx_data", rx_data, mdata);
    chk("frame_cnt", frame_cnt, mcnt);
    chk("err_code", err_code, mcode);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic send_frame(input vec_t v);
    bit errd;
    errd = 1'b0;
    sig1 = 1'b1; sig3 = 1'b0; sig2 = 1'($urandom);
    tick();
    chk("busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < v.nbits; i++) begin
      for (int s = 1; s < v.space; s++) begin
        sig3 = 1'b0; sig2 = 1'($urandom);
        tick();
      end
      sig3 = 1'b1; sig2 = v.bits[v.nbits-1-i];
      if (i == E) begin
        push(1'b1, v.code, 8'h00);
        errd = 1'b1;
      end
      tick();
      chk("busy_frame", 32'(busy), 32'(!errd));
    end
    sig1 = 1'b0; sig3 = v.cfall; sig2 = 1'($urandom);
    if (!errd) push(v.kerr, v.code, v.data);
    tick();
    chk("busy_end", 32'(busy), 32'd0);
    sig3 = 1'b0;
  endtask

  initial begin
    int ngood0;
    rst = 1'b1; sig1 = 1'b0; sig2 = 1'b0; sig3 = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("reset_rx_data", rx_data, 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_err", 32'(rx_err), 32'd0);
    chk("reset_err_code", 32'(err_code), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frame_cnt", frame_cnt, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();

    vecs.push_back(mkv(mk(8'hA5), E, 2, 1'b0, 1'b0, 2'b00, 8'hA5));
    vecs.push_back(mkv(16'h0016, 5, 2, 1'b0, 1'b1, 2'b01, 8'h00));
    vecs.push_back(mkv(mk(8'h3C), E, 1, 1'b0, 1'b0, 2'b00, 8'h3C));
    vecs.push_back(mkv((mk(8'h5A) << 1) | 16'h1, E + 1, 2, 1'b0, 1'b1, 2'b10, 8'h00));
    vecs.push_back(mkv(mk(8'h81), E, 3, 1'b0, 1'b0, 2'b00, 8'h81));
    vecs.push_back(mkv(mk(8'h96), E, 16, 1'b0, 1'b0, 2'b00, 8'h96));
    vecs.push_back(mkv(mk(8'hC3), E, 2, 1'b1, 1'b0, 2'b00, 8'hC3));
    vecs.push_back(mkv(mk(8'h00), E, 1, 1'b0, 1'b0, 2'b00, 8'h00));
`ifdef MYPROTO_RX_PARITY_EN
    vecs.push_back(mkv(mk(8'h07), E, 2, 1'b0, 1'b0, 2'b00, 8'h07));
    vecs.push_back(mkv(16'h000E, E, 2, 1'b0, 1'b1, 2'b00, 8'h00));
`endif
    foreach (vecs[k]) send_frame(vecs[k]);
    tick();
    chk("table_drained", exp_q.size(), 32'd0);

    // Timeout: sig1 high, no strobes.
    sig1 = 1'b1; sig3 = 1'b0;
    tick();
    push(1'b1, 2'b11, 8'h00);
    exp_q[exp_q.size()-1].due = cyc + 16;
    for (int i = 0; i < 16; i++) tick();
    chk("busy_after_timeout", 32'(busy), 32'd0);
    sig1 = 1'b0;
    tick(); tick();

    // Reset mid-frame; the remainder must be ignored.
    sig1 = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      sig3 = 1'b0; tick();
      sig3 = 1'b1; sig2 = 1'b1; tick();
    end
    sig3 = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_rx_data", rx_data, 32'd0);
    chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
    chk("midrst_rx_err", 32'(rx_err), 32'd0);
    chk("midrst_err_code", 32'(err_code), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_frame_cnt", frame_cnt, 32'd0);
    mdata = 8'd0; mcnt = 8'd0; mcode = 2'b00; exp_cnt = 8'd0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < E - 3; i++) begin
      sig3 = 1'b0; tick();
      sig3 = 1'b1; sig2 = 1'($urandom); tick();
      chk("busy_in_sync", 32'(busy), 32'd0);
    end
    sig1 = 1'b0; sig3 = 1'b0;
    tick();
    chk("sync_no_event", exp_q.size(), 32'd0);

    // 256 back-to-back good frames; count wraps back to zero.
    ngood0 = ngood;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] d;
      d = (i == 0) ? 8'hFF : 8'(i);
      send_frame(mkv(mk(d), E, 1, 1'b0, 1'b0, 2'b00, d));
    end
    tick();
    chk("wrap_frame_cnt", frame_cnt, 32'd0);
    chk("wrap_valid_pulses", ngood - ngood0, 32'd256);
    chk("final_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
